fdd_track_sequencer: RTL and testbench

- Sequences all SD-side traffic for the Disk II track buffer.
- On a head track change or a new image mount, it first writes back any dirty sectors of the cached track, then loads all sectors of the new track into the dual-port track RAM.
- It drives sd_rd/sd_wr/sd_lba for SD slot 0, drives the track_sec select for the buffer's SD-side address, and stalls the CPU while it is busy.

---
 rtl/fdd_track_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_fdd_track_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdd_track_sequencer.sv
// fdd_track_sequencer
//   Moves Disk II track data between the SD card (slot 0) and the
//   dual-port track RAM. On a head track change or a fresh image mount it
//   writes back any dirty sectors of the cached track and then loads all
//   SECTORS sectors of the new track, one SD request per sector. The CPU
//   is stalled (cpu_wait) for the whole sequence.
//
//   Build option: define FDD_WRITEBACK_EN to enable the dirty bitmap and
//   the write-back (FLUSH) states. Without it the buffer is read-only:
//   sd_wr is tied low and drive-side writes are lost on a track change.
//
// Ports
//   CLK_VIDEO      clock, all logic on the rising edge
//   reset          synchronous, active-high
//   track          current head track from the drive model
//   img_mounted    pulse, image (re)mounted on slot 0
//   img_size_nz    mounted image has a non-zero size
//   fd_write_disk  drive-side write strobe into the track RAM
//   fd_track_addr  drive-side track RAM address, [SEC_W+8:9] = sector
//   sd_ack         SD host acknowledge
//   sd_rd, sd_wr   sector read / write request
//   sd_lba         sector LBA = SECTORS*track + sector
//   track_sec      sector select for the SD-side port of the track RAM
//   cpu_wait       CPU stall, registered copy of busy
//   busy           sequencer not idle
module fdd_track_sequencer #(
  parameter int SECTORS = 13,
  parameter int TRACK_W = 6,
  parameter int SEC_W   = 4
) (
  input  logic               CLK_VIDEO,
  input  logic               reset,
  input  logic [TRACK_W-1:0] track,
  input  logic               img_mounted,
  input  logic               img_size_nz,
  input  logic               fd_write_disk,
  input  logic [SEC_W+8:0]   fd_track_addr,
  input  logic               sd_ack,
  output logic               sd_rd,
  output logic               sd_wr,
  output logic [31:0]        sd_lba,
  output logic [SEC_W-1:0]   track_sec,
  output logic               cpu_wait,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_REQ   = 3'd1,
    LOAD_XFER  = 3'd2
`ifdef FDD_WRITEBACK_EN
    ,
    FLUSH_REQ  = 3'd3,
    FLUSH_XFER = 3'd4
`endif
  } state_t;

  state_t             r_state, w_state_next;
  logic [SEC_W-1:0]   r_sec, w_sec_next;
  logic [TRACK_W-1:0] r_new_track, w_new_track_next;
  logic [TRACK_W-1:0] r_cur_track, w_cur_track_next;
  logic               r_valid, w_valid_next;
  logic               r_mount_pend, w_mount_pend_next;
  logic               r_old_ack;
  logic               r_sd_rd, w_sd_rd_next;
  logic               r_sd_wr, w_sd_wr_next;
  logic [31:0]        r_sd_lba, w_sd_lba_next;
  logic [SEC_W-1:0]   r_track_sec, w_track_sec_next;
  logic               r_cpu_wait, w_cpu_wait_next;

  logic w_ack_rise, w_ack_fall, w_mount, w_last_sec;

  assign w_ack_rise = sd_ack & ~r_old_ack;
  assign w_ack_fall = ~sd_ack & r_old_ack;
  // A mount pulse arriving in the same cycle as the IDLE decision counts
  // as pending, so a mount can never trigger a second, redundant reload.
  assign w_mount    = r_mount_pend | img_mounted;
  assign w_last_sec = (r_sec == SEC_W'(SECTORS - 1));

  function automatic logic [31:0] f_lba(input logic [TRACK_W-1:0] trk,
                                        input logic [SEC_W-1:0]   sec);
    f_lba = 32'(SECTORS) * 32'(trk) + 32'(sec);
  endfunction

`ifdef FDD_WRITEBACK_EN
  logic [SECTORS-1:0] r_dirty, w_dirty_next, w_dirty_set;
  logic [SEC_W-1:0]   w_wr_sec;
  logic               w_wr_accept;
  logic               w_unused_addr;

  assign w_wr_sec      = fd_track_addr[SEC_W+8:9];
  assign w_unused_addr = ^fd_track_addr[8:0];

  // While flushing, only a write hitting the sector in flight is kept:
  // it re-marks that sector so it is written back again.
  assign w_wr_accept = fd_write_disk &&
                       ((r_state == IDLE) || (r_state == LOAD_REQ) ||
                        (r_state == LOAD_XFER) ||
                        ((r_state == FLUSH_XFER) && (w_wr_sec == r_sec)));

  // Sector numbers >= SECTORS have no bit and are dropped here.
  for (genvar gi = 0; gi < SECTORS; gi++) begin : g_dirty_set
    assign w_dirty_set[gi] = w_wr_accept && (w_wr_sec == SEC_W'(gi));
  end

  function automatic logic [SEC_W-1:0] f_lowest(input logic [SECTORS-1:0] v);
    f_lowest = '0;
    for (int i = SECTORS - 1; i >= 0; i--) begin
      if (v[i]) f_lowest = SEC_W'(i);
    end
  endfunction
`else
  logic w_unused_wr;
  assign w_unused_wr = ^{fd_write_disk, fd_track_addr};
`endif

  always_comb begin
    w_state_next      = r_state;
    w_sec_next        = r_sec;
    w_new_track_next  = r_new_track;
    w_cur_track_next  = r_cur_track;
    w_valid_next      = r_valid;
    w_mount_pend_next = r_mount_pend | img_mounted;
`ifdef FDD_WRITEBACK_EN
    w_dirty_next      = r_dirty | w_dirty_set;
`endif
    case (r_state)
      IDLE: begin
        // IDLE either consumes a pending mount or, with no image, drops it.
        w_mount_pend_next = 1'b0;
        if (img_size_nz && (w_mount || (track != r_cur_track) || !r_valid)) begin
          w_new_track_next = track;
          w_sec_next       = '0;
          w_state_next     = LOAD_REQ;
`ifdef FDD_WRITEBACK_EN
          // A remount discards dirty data: the old image is gone.
          if (r_valid && (r_dirty != '0) && !w_mount) begin
            w_state_next = FLUSH_REQ;
            w_sec_next   = f_lowest(r_dirty);
          end else begin
            w_dirty_next = '0;
          end
`endif
        end
      end
`ifdef FDD_WRITEBACK_EN
      FLUSH_REQ: begin
        if (w_ack_rise) begin
          w_dirty_next[r_sec] = 1'b0;
          w_state_next        = FLUSH_XFER;
        end
      end
      FLUSH_XFER: begin
        if (w_ack_fall) begin
          if (r_dirty != '0) begin
            w_sec_next   = f_lowest(r_dirty);
            w_state_next = FLUSH_REQ;
          end else begin
            w_sec_next   = '0;
            w_state_next = LOAD_REQ;
          end
        end
      end
`endif
      LOAD_REQ: begin
        if (w_ack_rise) w_state_next = LOAD_XFER;
      end
      LOAD_XFER: begin
        if (w_ack_fall) begin
          if (w_last_sec) begin
            w_cur_track_next = r_new_track;
            w_valid_next     = 1'b1;
            w_state_next     = IDLE;
          end else begin
            w_sec_next   = r_sec + SEC_W'(1);
            w_state_next = LOAD_REQ;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase

    // Request outputs are registered decodes of the next state, so the
    // LBA and sector select only move when a new request is issued.
    w_sd_rd_next     = (w_state_next == LOAD_REQ);
    w_sd_wr_next     = 1'b0;
    w_cpu_wait_next  = (w_state_next != IDLE);
    w_track_sec_next = r_track_sec;
    w_sd_lba_next    = r_sd_lba;
    if (w_state_next == LOAD_REQ) begin
      w_track_sec_next = w_sec_next;
      w_sd_lba_next    = f_lba(w_new_track_next, w_sec_next);
    end
`ifdef FDD_WRITEBACK_EN
    if (w_state_next == FLUSH_REQ) begin
      w_sd_wr_next     = 1'b1;
      w_track_sec_next = w_sec_next;
      w_sd_lba_next    = f_lba(r_cur_track, w_sec_next);
    end
`endif
  end

  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      r_state      <= IDLE;
      r_sec        <= '0;
      r_new_track  <= '0;
      r_cur_track  <= '0;
      r_valid      <= 1'b0;
      r_mount_pend <= 1'b0;
      r_old_ack    <= 1'b0;
      r_sd_rd      <= 1'b0;
      r_sd_wr      <= 1'b0;
      r_sd_lba     <= '0;
      r_track_sec  <= '0;
      r_cpu_wait   <= 1'b0;
`ifdef FDD_WRITEBACK_EN
      r_dirty      <= '0;
`endif
    end else begin
      r_state      <= w_state_next;
      r_sec        <= w_sec_next;
      r_new_track  <= w_new_track_next;
      r_cur_track  <= w_cur_track_next;
      r_valid      <= w_valid_next;
      r_mount_pend <= w_mount_pend_next;
      r_old_ack    <= sd_ack;
      r_sd_rd      <= w_sd_rd_next;
      r_sd_wr      <= w_sd_wr_next;
      r_sd_lba     <= w_sd_lba_next;
      r_track_sec  <= w_track_sec_next;
      r_cpu_wait   <= w_cpu_wait_next;
`ifdef FDD_WRITEBACK_EN
      r_dirty      <= w_dirty_next;
`endif
    end
  end

  assign sd_rd     = r_sd_rd;
  assign sd_wr     = r_sd_wr;
  assign sd_lba    = r_sd_lba;
  assign track_sec = r_track_sec;
  assign cpu_wait  = r_cpu_wait;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_fdd_track_sequencer.sv
// Self-checking bench for fdd_track_sequencer. A reference model computes,
// for every track change or mount, the list of SD requests the sequence
// must issue (write-backs of dirty sectors in ascending order, then reads
// of every sector of the new track) and queues them. A monitor pops one
// entry per request the DUT raises; an SD host model acks with random
// delays. Works with and without FDD_WRITEBACK_EN.
module tb_fdd_track_sequencer;
  localparam int SECTORS = 13;
  localparam int TRACK_W = 6;
  localparam int SEC_W   = 4;

  logic               CLK_VIDEO = 1'b0;
  logic               reset = 1'b1;
  logic [TRACK_W-1:0] track = '0;
  logic               img_mounted = 1'b0;
  logic               img_size_nz = 1'b0;
  logic               fd_write_disk = 1'b0;
  logic [SEC_W+8:0]   fd_track_addr = '0;
  logic               sd_ack = 1'b0;
  logic               sd_rd, sd_wr, cpu_wait, busy;
  logic [31:0]        sd_lba;
  logic [SEC_W-1:0]   track_sec;

  fdd_track_sequencer #(.SECTORS(SECTORS), .TRACK_W(TRACK_W), .SEC_W(SEC_W)) dut (
    .CLK_VIDEO(CLK_VIDEO), .reset(reset), .track(track),
    .img_mounted(img_mounted), .img_size_nz(img_size_nz),
    .fd_write_disk(fd_write_disk), .fd_track_addr(fd_track_addr),
    .sd_ack(sd_ack), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_lba(sd_lba),
    .track_sec(track_sec), .cpu_wait(cpu_wait), .busy(busy)
  );

  always #5 CLK_VIDEO = ~CLK_VIDEO;

  typedef struct { bit wr; int lba; int sec; } req_t;
  req_t exp_q[$];
  req_t mon_e;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int       m_cur = 0;
  bit       m_valid = 1'b0;
  bit [15:0] m_dirty = '0;

  // SD host model state
  int acks_given = 0;
  int ack_limit  = 32'h7fffffff;
  int hs = 0;
  int hdly = 0;

  // monitor state
  int          ph = 0;
  logic [31:0] cur_lba;
  logic [3:0]  cur_sec;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Returns 1 if a load sequence must start; queues its requests.
  function automatic bit model_trigger(input int trk, input bit mnt);
    if (!(mnt || trk != m_cur || !m_valid)) return 1'b0;
`ifdef FDD_WRITEBACK_EN
    if (m_valid && !mnt)
      for (int s = 0; s < SECTORS; s++)
        if (m_dirty[s]) exp_q.push_back('{1'b1, SECTORS * m_cur + s, s});
`endif
    for (int s = 0; s < SECTORS; s++)
      exp_q.push_back('{1'b0, SECTORS * trk + s, s});
    m_cur   = trk;
    m_valid = 1'b1;
    m_dirty = '0;
    return 1'b1;
  endfunction

  // SD host: ack each request after 0..3 cycles, release 0..3 cycles
  // after the request drops.
  initial begin
    forever begin
      @(negedge CLK_VIDEO);
      if (reset) begin
        sd_ack = 1'b0;
        hs = 0;
      end else begin
        case (hs)
          0: if ((sd_rd || sd_wr) && acks_given < ack_limit) begin
               hdly = $urandom_range(0, 3); hs = 1;
             end
          1: if (hdly == 0) begin sd_ack = 1'b1; acks_given++; hs = 2; end
             else hdly--;
          2: if (!sd_rd && !sd_wr) begin hdly = $urandom_range(0, 3); hs = 3; end
          3: if (hdly == 0) begin sd_ack = 1'b0; hs = 0; end
             else hdly--;
          default: hs = 0;
        endcase
      end
    end
  end

  task automatic mon_pop();
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL unexpected_req: actual rd=%0b wr=%0b lba=%0d required=no request",
               sd_rd, sd_wr, sd_lba);
    end else begin
      mon_e = exp_q.pop_front();
      $display("req %s lba=%0d sec=%0d (expected %s lba=%0d sec=%0d)",
               sd_wr ? "WR" : "RD", sd_lba, track_sec,
               mon_e.wr ? "WR" : "RD", mon_e.lba, mon_e.sec);
      chk("req_wr",  sd_wr, mon_e.wr);
      chk("req_rd",  sd_rd, !mon_e.wr);
      chk("req_lba", sd_lba, mon_e.lba);
      chk("req_sec", track_sec, mon_e.sec);
    end
    cur_lba = sd_lba;
    cur_sec = track_sec;
    ph = 1;
  endtask

  // Monitor: samples just after each rising edge.
  initial begin
    forever begin
      @(posedge CLK_VIDEO); #1;
      if (reset) begin
        ph = 0;
      end else begin
        chk("rd_wr_exclusive", sd_rd & sd_wr, 0);
        chk("cpu_wait_eq_busy", cpu_wait, busy);
        case (ph)
          0: if (sd_rd || sd_wr) mon_pop();
          1: begin
               chk("lba_stable", sd_lba, cur_lba);
               chk("sec_stable", track_sec, cur_sec);
               if (!sd_rd && !sd_wr) ph = 2;
             end
          default: begin
               if (!sd_ack) begin
                 ph = 0;
                 if (sd_rd || sd_wr) mon_pop();
               end else begin
                 chk("lba_stable", sd_lba, cur_lba);
                 chk("sec_stable", track_sec, cur_sec);
               end
             end
        endcase
      end
    end
  end

  task automatic wait_seq();
    int n = 0;
    while (!busy && n < 20) begin @(negedge CLK_VIDEO); n++; end
    chk("busy_rose", busy, 1);
    n = 0;
    while (busy && n < 5000) begin @(negedge CLK_VIDEO); n++; end
    chk("busy_fell", busy, 0);
    chk("cpu_wait_end", cpu_wait, 0);
  endtask

  task automatic idle_check(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      chk("idle_busy", busy, 0);
      chk("idle_cpu_wait", cpu_wait, 0);
      @(negedge CLK_VIDEO);
    end
  endtask

  task automatic do_write(input int s);
    fd_track_addr = {4'(s), 9'($urandom)};
    fd_write_disk = 1'b1;
    @(negedge CLK_VIDEO);
    fd_write_disk = 1'b0;
    if (s < SECTORS) m_dirty[s] = 1'b1;
  endtask

  task automatic do_change(input int trk, input bit mnt);
    bit exp_seq;
    exp_seq = model_trigger(trk, mnt);
    track = TRACK_W'(trk);
    img_mounted = mnt;
    @(negedge CLK_VIDEO);
    img_mounted = 1'b0;
    if (exp_seq) wait_seq();
    else idle_check(6);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  // Reset while the 4th load request is waiting for its ack.
  task automatic reset_test(input int trk);
    int n = 0;
    bit exp_seq;
    ack_limit = acks_given + 3;
    exp_seq = model_trigger(trk, 1'b0);
    track = TRACK_W'(trk);
    while (!(sd_rd && !sd_ack && acks_given == ack_limit) && n < 500) begin
      @(negedge CLK_VIDEO); n++;
    end
    chk("rst_4th_lba", sd_lba, SECTORS * trk + 3);
    reset = 1'b1;
    @(posedge CLK_VIDEO); #1;
    chk("rst_sd_rd", sd_rd, 0);
    chk("rst_cpu_wait", cpu_wait, 0);
    chk("rst_busy", busy, 0);
    exp_q.delete();
    m_valid = 1'b0; m_dirty = '0; m_cur = 0;
    @(negedge CLK_VIDEO);
    exp_seq = model_trigger(trk, 1'b0);
    ack_limit = 32'h7fffffff;
    reset = 1'b0;
    if (exp_seq) wait_seq();
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge CLK_VIDEO);
    #1;
    chk("reset_sd_rd", sd_rd, 0);
    chk("reset_sd_wr", sd_wr, 0);
    chk("reset_sd_lba", sd_lba, 0);
    chk("reset_track_sec", track_sec, 0);
    chk("reset_cpu_wait", cpu_wait, 0);
    chk("reset_busy", busy, 0);
    @(negedge CLK_VIDEO);
    reset = 1'b0;
    idle_check(3);

    img_size_nz = 1'b1;
    do_change(0, 1'b1);            // mount: LBA 0..12
    do_change(5, 1'b0);            // LBA 65..77
    do_write(2); do_write(9);
    do_change(6, 1'b0);            // write-back 67, 74 then 78..90
    reset_test(7);
    do_write(4); do_write(14);
    do_change(m_cur, 1'b1);        // remount discards dirty data

    img_size_nz = 1'b0;            // mount of an empty image: nothing
    img_mounted = 1'b1;
    @(negedge CLK_VIDEO);
    img_mounted = 1'b0;
    idle_check(8);
    img_size_nz = 1'b1;
    idle_check(4);

    do_write(2);
    do_change(8, 1'b0);

    for (int it = 0; it < 25; it++) begin
      int act, nw;
      act = $urandom_range(0, 9);
      nw  = $urandom_range(0, 3);
      for (int k = 0; k < nw; k++) do_write($urandom_range(0, 15));
      if (act < 6)      do_change($urandom_range(0, 63), 1'b0);
      else if (act < 8) do_change(m_cur, 1'b1);
      else              idle_check(3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
